// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters with registered, mutually aligned sync/blank decode.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic        frame_start,
    output logic [15:0] frame_cnt
`else
    output logic        frame_start
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] HB_FIRST  = 11'(H_ACTIVE);
    localparam logic [10:0] VB_FIRST  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        frame_start_q, frame_start_d;

    // pix_en is a plain advance strobe (no handshake): each pclk edge with pix_en=1 moves
    // the raster one pixel; with pix_en=0 everything holds except frame_start, which clears.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;
        if (pix_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = 11'd0;
                if (vcount_q == V_LAST) begin
                    vcount_d      = 11'd0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 11'd1;
                end
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end
    end

    // Decode from the next-state counters so the registered flags line up with hcount/vcount.
    always_comb begin
        hblnk_d = (hcount_d >= HB_FIRST);
        vblnk_d = (vcount_d >= VB_FIRST);
        hsync_d = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? H_POL : ~H_POL;
        vsync_d = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? V_POL : ~V_POL;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_q      <= 11'd0;
            vcount_q      <= 11'd0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hblnk       = hblnk_q;
    assign vblnk       = vblnk_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster timing every draw stage in the VGA pipeline consumes: hcount/vcount, hsync/vsync and hblnk/vblnk.
- Sits at the head of the pipeline and feeds the first draw stage (background), which passes the signals on down the chain.
- Default timing is 800x600@60 Hz with a 40 MHz pixel clock. All outputs are registered and mutually aligned.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels); H_TOTAL = sum = 1056
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines); V_TOTAL = sum = 628
- H_POL, 1, active level of hsync (1 = active-high)
- V_POL, 1, active level of vsync

Ports:
- pclk  input  1  pixel clock; all logic is on the rising edge
- rst  input  1  synchronous, active-high reset
- pix_en  input  1  advance strobe; counters step only when high; tie to 1 for full rate
- hcount  output  11  pixel index within line, 0..H_TOTAL-1
- vcount  output  11  line index within frame, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, level set by H_POL
- vsync  output  1  vertical sync, level set by V_POL
- hblnk  output  1  high when hcount >= H_ACTIVE
- vblnk  output  1  high when vcount >= V_ACTIVE
- frame_start  output  1  one-cycle pulse when counters step to (0,0)

Behaviour:
- Reset (rst=1 at a pclk edge): hcount=0, vcount=0, hblnk=0, vblnk=0, frame_start=0, hsync=~H_POL, vsync=~V_POL.
  - Reset takes priority over pix_en.
  - Reset mid-frame restarts at (0,0) on the next cycle; no partial-line completion.
- Counting (pix_en=1):
  - If hcount==H_TOTAL-1: hcount<=0.
    - If also vcount==V_TOTAL-1: vcount<=0.
    - Otherwise vcount<=vcount+1.
  - Otherwise hcount<=hcount+1 and vcount holds.
- pix_en=0: every output holds its value, except frame_start, which drops to 0.
- Decode alignment: hsync, vsync, hblnk and vblnk are registered from the next-state counter values. Each therefore corresponds exactly to the hcount/vcount present in the same cycle, with zero relative latency.
- Horizontal decode:
  - hblnk = (hcount >= H_ACTIVE).
  - hsync is active when H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1, i.e. 840..967 by default.
- Vertical decode:
  - vblnk = (vcount >= V_ACTIVE).
  - vsync is active when V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1, i.e. 601..604 by default.
  - vsync and vblnk change only in the cycle where hcount becomes 0.
- frame_start is 1 for exactly the one cycle in which (hcount,vcount) has just become (0,0) due to a wrap.
  - It is not asserted on exit from reset.
  - It is not re-asserted while pix_en=0 holds at (0,0).
- Widths:
  - Counters are 11 bits; H_TOTAL and V_TOTAL must be <= 2048.
  - Comparisons are unsigned. No overflow is possible inside range.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- When defined:
  - Adds output port frame_cnt (16 bits).
  - Reset value 0.
  - Increments by 1 in the same cycle frame_start asserts.
  - Wraps from 0xFFFF to 0.
  - Intended for blink/animation timing in the credits/menu draw stages.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 3 cycles, then release with pix_en=1.
  - Required: hcount=0, vcount=0, all blanks 0, syncs inactive, frame_start=0 on the first cycle after release.
  - Required: hcount=5 after 5 further cycles.
- Horizontal line: pix_en=1 from (0,0).
  - hblnk rises when hcount=800.
  - hsync is active for hcount 840..967 (128 cycles) and inactive at 968.
  - At hcount 1055 the next cycle gives hcount=0, vcount=1, hblnk=0.
- Frame wrap: run 1056*628 = 663168 cycles.
  - vblnk is high for vcount 600..627.
  - vsync is active for vcount 601..604.
  - Counters return to (0,0) with frame_start=1 for exactly one cycle, then 0.
  - With VGA_TIMING_FRAME_CNT_EN defined, frame_cnt=1.
- Enable gating: toggle pix_en 1,0 alternately.
  - Required: hcount advances by 1 per two cycles.
  - Required: a line takes 2112 cycles.
  - If pix_en drops in the wrap cycle, frame_start lasts one cycle only.
- Mid-frame reset: assert rst at hcount=900, vcount=602, while hsync and vsync are both active.
  - Required: next cycle all outputs are at reset values, syncs inactive.
- Parameter override: H_POL=0, V_POL=0 with 640x480 values (640/16/96/48, 480/10/2/33).
  - Required: hsync is low only at hcount 656..751.
  - Required: vsync is low only at vcount 490..491.
  - Required: the line wraps at 799 and the frame at 524.
